// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one external combinational ALU between two requesters.
// Round-robin arbitration with one operation in flight. Operands and results
// are registered. MUL/DIV hold the ALU inputs for WAIT_CYC extra cycles.
// Divide-by-zero is answered directly with an error response.
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where VALID and READY are both high. A producer holding VALID keeps its
// payload stable until that edge. READY never depends combinationally on the
// consumer's own READY, and all READY/VALID outputs are 0 while i_rst_n is low.
module alu_scheduler #(
    parameter int DW       = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // requester 0
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [DW-1:0] i_req0_op1,
    input  logic [DW-1:0] i_req0_op2,
    input  logic [2:0]    i_req0_op,
    // requester 1
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic [DW-1:0] i_req1_op1,
    input  logic [DW-1:0] i_req1_op2,
    input  logic [2:0]    i_req1_op,
    // responses (payload shared, VALID per requester)
    output logic          o_rsp0_valid,
    output logic          o_rsp1_valid,
    input  logic          i_rsp0_ready,
    input  logic          i_rsp1_ready,
    output logic [DW-1:0] o_rsp_ops,
    output logic          o_rsp_zf,
    output logic          o_rsp_err,
    // external ALU
    output logic [DW-1:0] o_alu_op1,
    output logic [DW-1:0] o_alu_op2,
    output logic [2:0]    o_alu_op,
    input  logic [DW-1:0] i_alu_ops,
    input  logic          i_alu_zf,
    // status / debug
    output logic          o_busy,
    output logic [1:0]    o_state
);

    localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam logic [2:0] OP_DIV = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last;
    logic          r_gnt;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_alu_op1;
    logic [DW-1:0] r_alu_op2;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_rsp_ops;
    logic          r_rsp_zf;
    logic          r_rsp_err;

    logic          w_req_any;
    logic          w_gnt;
    logic          w_accept;
    logic [DW-1:0] w_sel_op1;
    logic [DW-1:0] w_sel_op2;
    logic [2:0]    w_sel_op;
    logic          w_div0;
    logic          w_long;
    logic          w_rsp_ready_g;
    logic          w_cnt_zero;

    // Arbitration and request selection; on a tie the requester that was not served last wins.
    always_comb begin
        w_req_any     = i_req0_valid | i_req1_valid;
        w_gnt         = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
        w_sel_op1     = w_gnt ? i_req1_op1 : i_req0_op1;
        w_sel_op2     = w_gnt ? i_req1_op2 : i_req0_op2;
        w_sel_op      = w_gnt ? i_req1_op  : i_req0_op;
        w_div0        = (w_sel_op == OP_DIV) && (w_sel_op2 == '0);
        w_long        = (w_sel_op == OP_DIV) || (w_sel_op == OP_MUL);
        w_accept      = (r_state == S_IDLE) && w_req_any;
        w_rsp_ready_g = r_gnt ? i_rsp1_ready : i_rsp0_ready;
        w_cnt_zero    = (r_cnt == '0);
    end

    // Next-state logic: divide-by-zero skips EXEC, long ops wait for the counter.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_div0 ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cnt_zero) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_ready_g) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture, wait counter, result capture and round-robin history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_cnt     <= '0;
            r_alu_op1 <= '0;
            r_alu_op2 <= '0;
            r_alu_op  <= 3'b000;
            r_rsp_ops <= '0;
            r_rsp_zf  <= 1'b0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_op1 <= w_sel_op1;
                        r_alu_op2 <= w_sel_op2;
                        r_alu_op  <= w_sel_op;
                        r_gnt     <= w_gnt;
                        r_cnt     <= w_long ? CW'(WAIT_CYC) : '0;
                        if (w_div0) begin
                            r_rsp_ops <= {DW{1'b1}};
                            r_rsp_zf  <= 1'b0;
                            r_rsp_err <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_rsp_ops <= i_alu_ops;
                        r_rsp_zf  <= i_alu_zf;
                        r_rsp_err <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (w_rsp_ready_g) begin
                        r_last <= r_gnt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are gated by reset so they drop the moment reset asserts.
    always_comb begin
        o_req0_ready = i_rst_n & w_accept & ~w_gnt;
        o_req1_ready = i_rst_n & w_accept &  w_gnt;
        o_rsp0_valid = i_rst_n & (r_state == S_RESP) & ~r_gnt;
        o_rsp1_valid = i_rst_n & (r_state == S_RESP) &  r_gnt;
        o_rsp_ops    = r_rsp_ops;
        o_rsp_zf     = r_rsp_zf;
        o_rsp_err    = r_rsp_err;
        o_alu_op1    = r_alu_op1;
        o_alu_op2    = r_alu_op2;
        o_alu_op     = r_alu_op;
        o_busy       = (r_state != S_IDLE);
        o_state      = r_state;
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: models the external ALU, drives both
// requesters and checks responses against a queue of expected results.
module tb_alu_scheduler;

    localparam int DW       = 32;
    localparam int WAIT_CYC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]    req0_op, req1_op;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp_ops;
    logic          rsp_zf, rsp_err;
    logic [DW-1:0] alu_op1, alu_op2, alu_ops;
    logic [2:0]    alu_op;
    logic          alu_zf;
    logic          busy;
    logic [1:0]    state;

    int            n_cmp = 0;
    int            n_fail = 0;
    // {rsp0_valid, rsp1_valid, err, zf, result}
    logic [DW+3:0] exp_q[$];

    always #5 clk = ~clk;

    alu_scheduler #(.DW(DW), .WAIT_CYC(WAIT_CYC)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_op1(req0_op1), .i_req0_op2(req0_op2), .i_req0_op(req0_op),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_op1(req1_op1), .i_req1_op2(req1_op2), .i_req1_op(req1_op),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready),
        .o_rsp_ops(rsp_ops), .o_rsp_zf(rsp_zf), .o_rsp_err(rsp_err),
        .o_alu_op1(alu_op1), .o_alu_op2(alu_op2), .o_alu_op(alu_op),
        .i_alu_ops(alu_ops), .i_alu_zf(alu_zf),
        .o_busy(busy), .o_state(state)
    );

    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a ^ b;
            3'b101:  return (b == '0) ? '0 : a / b;
            3'b110:  return a << b[4:0];
            default: return a * b;
        endcase
    endfunction

    assign alu_ops = alu_f(alu_op, alu_op1, alu_op2);
    assign alu_zf  = (alu_ops == '0);

    function automatic logic [DW+3:0] model(input logic rid, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] res;
        if (op == 3'b101 && b == '0) return {~rid, rid, 1'b1, 1'b0, {DW{1'b1}}};
        res = alu_f(op, a, b);
        return {~rid, rid, 1'b0, (res == '0), res};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_req(input int r, input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            req0_op = op; req0_op1 = a; req0_op2 = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_op1 = a; req1_op2 = b; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rsp0_valid | rsp1_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        n_cmp++;
        if ({rsp_ops, rsp_zf, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h/%b/%b expected 0/0/0", rsp_ops, rsp_zf, rsp_err);
        end
        n_cmp++;
        if ({alu_op1, alu_op2, alu_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_alu: got %h %h %b expected zeros", alu_op1, alu_op2, alu_op);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single();
        logic [DW+3:0] exp_v, obs_v;
        drive_req(0, 3'b010, 32'd5, 32'd7);
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        exp_q.push_back(model(1'b0, 3'b010, 32'd5, 32'd7));
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if ({busy, rsp0_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_exec: busy/rsp0_valid got %b expected 10", {busy, rsp0_valid});
        end
        tick();
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_rsp: response with empty expected queue");
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_mul();
        logic [DW+3:0] exp_v, obs_v;
        drive_req(1, 3'b111, 32'd6, 32'd7);
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_ready: got %b expected 1", req1_ready);
        end
        exp_q.push_back(model(1'b1, 3'b111, 32'd6, 32'd7));
        tick();
        req1_valid = 1'b0;
        for (int j = 1; j <= WAIT_CYC + 1; j++) begin
            n_cmp++;
            if ({alu_op, alu_op1, alu_op2, rsp1_valid} !== {3'b111, 32'd6, 32'd7, 1'b0}) begin
                n_fail++;
                $display("FAIL mul_hold_%0d: alu %b %h %h rsp1_valid %b expected 111 6 7 0", j, alu_op, alu_op1, alu_op2, rsp1_valid);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL mul_rsp: response with empty expected queue");
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL mul_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
    endtask

    task automatic test_alternate();
        logic [DW+3:0] exp_v, obs_v;
        bit seen;
        bit exp_g;
        drive_req(0, 3'b011, 32'd9, 32'd9);
        drive_req(1, 3'b000, 32'd3, 32'd4);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_g = (k % 2) == 1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL alt_grant_%0d: ready1/ready0 got %b expected %b", k, {req1_ready, req0_ready}, (exp_g ? 2'b10 : 2'b01));
            end
            if (exp_g) exp_q.push_back(model(1'b1, 3'b000, 32'd3, 32'd4));
            else       exp_q.push_back(model(1'b0, 3'b011, 32'd9, 32'd9));
            tick();
            wait_rsp(10, seen);
            if (k == 2) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            n_cmp++;
            if (!seen || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL alt_rsp_%0d: seen %b queue %0d expected a response", k, seen, exp_q.size());
            end else begin
                exp_v = exp_q.pop_front();
                obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
                if (obs_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL alt_rsp_%0d: got %h expected %h", k, obs_v, exp_v);
                end
            end
            tick();
        end
    endtask

    task automatic test_div();
        logic [DW+3:0] exp_v, obs_v;
        int lat;
        drive_req(0, 3'b101, 32'd20, 32'd0);
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_ready: got %b expected 1", req0_ready);
        end
        exp_q.push_back(model(1'b0, 3'b101, 32'd20, 32'd0));
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL div0_rsp: response with empty expected queue");
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL div0_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
        drive_req(0, 3'b101, 32'd20, 32'd4);
        #1;
        exp_q.push_back(model(1'b0, 3'b101, 32'd20, 32'd4));
        tick();
        req0_valid = 1'b0;
        lat = 1;
        while (!rsp0_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat !== 2 + WAIT_CYC) begin
            n_fail++;
            $display("FAIL div_latency: got %0d expected %0d", lat, 2 + WAIT_CYC);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL div_rsp: response with empty expected queue");
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL div_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
    endtask

    task automatic test_hold();
        logic [DW+3:0] exp_v, obs_v;
        bit seen;
        rsp0_ready = 1'b0;
        drive_req(0, 3'b010, 32'd1, 32'd2);
        #1;
        exp_q.push_back(model(1'b0, 3'b010, 32'd1, 32'd2));
        tick();
        req0_valid = 1'b0;
        drive_req(1, 3'b100, 32'hF0, 32'h0F);
        #1;
        wait_rsp(10, seen);
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL hold_rsp_seen: no response within 10 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({rsp0_valid, req1_ready, rsp_err, rsp_zf, rsp_ops} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd3}) begin
                n_fail++;
                $display("FAIL hold_stable_%0d: valid %b ready1 %b err %b zf %b ops %h expected 1 0 0 0 3", i, rsp0_valid, req1_ready, rsp_err, rsp_zf, rsp_ops);
            end
            tick();
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL hold_rsp: response with empty expected queue");
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL hold_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        rsp0_ready = 1'b1;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_grant_in_resp: ready1 got %b expected 0", req1_ready);
        end
        tick();
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_grant_after: ready1 got %b expected 1", req1_ready);
        end
        exp_q.push_back(model(1'b1, 3'b100, 32'hF0, 32'h0F));
        tick();
        req1_valid = 1'b0;
        wait_rsp(10, seen);
        n_cmp++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL hold_rsp1: seen %b queue %0d expected a response", seen, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL hold_rsp1: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [DW+3:0] exp_v, obs_v;
        bit seen;
        bit stray;
        drive_req(0, 3'b111, 32'd3, 32'd5);
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        drive_req(0, 3'b010, 32'd1, 32'd1);
        drive_req(1, 3'b010, 32'd2, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b expected 00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        exp_q.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp0_valid | rsp1_valid | busy) stray = 1'b1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: activity got %b expected 0", stray);
        end
        drive_req(0, 3'b010, 32'd100, 32'd23);
        drive_req(1, 3'b011, 32'd50, 32'd8);
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midreset_tie: ready1/ready0 got %b expected 01", {req1_ready, req0_ready});
        end
        exp_q.push_back(model(1'b0, 3'b010, 32'd100, 32'd23));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(10, seen);
        n_cmp++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL midreset_rsp: seen %b queue %0d expected a response", seen, exp_q.size());
        end else begin
            exp_v = exp_q.pop_front();
            obs_v = {rsp0_valid, rsp1_valid, rsp_err, rsp_zf, rsp_ops};
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL midreset_rsp: got %h expected %h", obs_v, exp_v);
            end
        end
        tick();
    endtask

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op1 = '0; req0_op2 = '0; req0_op = 3'b000;
        req1_op1 = '0; req1_op2 = '0; req1_op = 3'b000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_single();
        test_mul();
        test_alternate();
        test_div();
        test_hold();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares the single combinational 32-bit ALU between two requesters (REQ0, REQ1).
- Round-robin arbitration, one operation in flight, registered operands and result.
- Valid/ready handshakes on both the request and response sides.
- Holds operands stable for extra cycles on MUL/DIV (timing budget) and intercepts divide-by-zero before the ALU sees it.

Parameters:
DW, 32, operand/result width
WAIT_CYC, 2, extra EXEC cycles for OP=101 (div) and OP=111 (mul); 0 allowed

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
REQ0_VALID  in  1  requester 0 has an operation
REQ0_READY  out  1  requester 0 accepted this cycle
REQ0_OP1 / REQ0_OP2  in  DW  requester 0 operands
REQ0_OP  in  3  requester 0 ALU opcode
REQ1_VALID, REQ1_READY, REQ1_OP1, REQ1_OP2, REQ1_OP  —  same as REQ0 for requester 1
RSP0_VALID / RSP1_VALID  out  1  result valid for requester 0 / 1
RSP0_READY / RSP1_READY  in  1  requester takes result
RSP_OPS  out  DW  result, shared by both response channels
RSP_ZF  out  1  zero flag of result
RSP_ERR  out  1  divide-by-zero flag
ALU_OP1 / ALU_OP2  out  DW  to ALU operand inputs
ALU_OP  out  3  to ALU opcode
ALU_OPS  in  DW  from ALU result
ALU_ZF  in  1  from ALU zero flag
BUSY  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock CLK; RST_N asynchronous, active-low.
- Reset values: state IDLE; ALU_OP1/ALU_OP2/RSP_OPS = 0; ALU_OP = 3'b000; RSP_ZF/RSP_ERR = 0; all VALID/READY outputs 0; BUSY 0; LAST = 1, so REQ0 wins the first tie.
- Reset mid-operation: in-flight op discarded, no response issued.
- READY/VALID outputs are forced 0 while RST_N is low.
- States: IDLE, EXEC, RESP.
- IDLE arbitration (combinational):
  - Only one REQx_VALID → grant x.
  - Both valid → grant the requester != LAST.
  - REQg_READY = 1 only for the granted requester; the other READY = 0.
- Accept, on REQg_VALID & REQg_READY:
  - Register OP1/OP2/OP into ALU_OP1/ALU_OP2/ALU_OP; record GNT = g.
  - Load CNT = WAIT_CYC for OP 101/111, else 0.
  - Divide-by-zero (OP=101, OP2=0): go straight to RESP with RSP_OPS = 32'hFFFFFFFF, RSP_ZF = 0, RSP_ERR = 1.
  - Otherwise go to EXEC.
- EXEC:
  - ALU inputs held constant from registers.
  - CNT != 0 → decrement.
  - CNT == 0 → capture ALU_OPS→RSP_OPS, ALU_ZF→RSP_ZF, RSP_ERR = 0; go to RESP.
- RESP:
  - RSPg_VALID = 1 (other RSP VALID 0); RSP_OPS/ZF/ERR stable until handshake.
  - On RSPg_READY → IDLE, LAST = GNT.
  - No REQ READY while in EXEC or RESP.
- Latency, request accepted at edge N:
  - Normal ops: RSP_VALID rises after edge N+1.
  - Ops 101/111: after edge N+1+WAIT_CYC.
  - Divide-by-zero: after edge N.
- Throughput: RSP_READY held high gives minimum 3 cycles per normal op (accept, EXEC, RESP).
- Simultaneous events:
  - A request arriving during the RESP handshake cycle is not accepted that cycle; it is arbitrated in the following IDLE cycle.
  - A requester dropping VALID while not granted is legal. Once VALID is high it must hold request fields stable until READY.
- ALU_* outputs keep the last operation's values after it completes; the ALU sees no glitches between ops.

Test Plan:
- Reset, then REQ0 single request OP=010, 5+7 → REQ0_READY at cycle 0; RSP0_VALID 2 cycles after accept; RSP_OPS=12, ZF=0, ERR=0.
- REQ0 and REQ1 both valid continuously (REQ0: 9−9 OP=011; REQ1: 3&4 OP=000), RSP_READY=1 → grants alternate REQ0, REQ1, REQ0. Responses 0/ZF=1 and 0/ZF=1 routed to the correct RSPx_VALID.
- REQ1 OP=111, 6*7, WAIT_CYC=2 → ALU_OP/ALU_OP1/ALU_OP2 stable 3 cycles; RSP1_VALID at accept+4; RSP_OPS=42.
- REQ0 OP=101 with OP2=0 → RSP0_VALID the cycle after accept; RSP_OPS=FFFFFFFF, RSP_ERR=1, ZF=0. Then OP=101, 20/4 → 5, ERR=0.
- Hold RSP0_READY=0 for 5 cycles with REQ1 pending → RSP outputs stable, REQ1_READY=0 throughout; REQ1 granted the cycle after the RSP0 handshake.
- Drop RST_N during EXEC of a MUL → BUSY, all VALID/READY 0 immediately; no response after release; next tie grants REQ0.
